// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter: FSM state
// encodings, access opcodes and the default starvation threshold.
package mem_port_arbiter_pkg;

  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int STARVE_W           = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  function automatic logic is_serve(input state_e s);
    return (s == SERVE_I) || (s == SERVE_D);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive arbitrations the fetch side has lost.
module starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  output logic                sat,
  output logic [STARVE_W-1:0] count
);

  localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(MAX);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + STARVE_W'(1);
    end
  end

  assign sat = (count == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and the MEM
// stage; data wins unless fetch has lost STARVE_MAX arbitrations in a row.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_cancel,
  input  logic            d_req,
  input  logic            d_write,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            if_done,
  output logic            d_done,
  output logic [XLEN-1:0] if_rdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            if_stall,
  output logic            d_stall,
  output logic            mem_valid,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  state_e                state;
  state_e                next_state;
  logic                  grant_i;
  logic                  grant_d;
  logic                  squash;
  logic                  starve_sat;
  logic [STARVE_W-1:0]   starve_cnt;
  logic [XLEN-1:0]       lat_addr;
  logic [XLEN-1:0]       lat_wdata;
  op_e                   lat_op;

  starve_counter #(.MAX(STARVE_MAX)) u_starve_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_d && if_req),
    .clr   (grant_i),
    .sat   (starve_sat),
    .count (starve_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first; without it a path
  // that skips an assignment would infer a latch.
  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && !(if_req && starve_sat)) begin
          grant_d    = 1'b1;
          next_state = SERVE_D;
        end else if (if_req) begin
          grant_i    = 1'b1;
          next_state = SERVE_I;
        end
      end
      SERVE_I: if (mem_ready) next_state = RESP_I;
      SERVE_D: if (mem_ready) next_state = RESP_D;
      RESP_I,
      RESP_D:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The memory side only ever sees these registers, so requester inputs may
  // change freely while a transaction is outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_op    <= OP_READ;
    end else if (grant_d) begin
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata;
      lat_op    <= d_write ? OP_WRITE : OP_READ;
    end else if (grant_i) begin
      lat_addr  <= if_addr;
      lat_wdata <= '0;
      lat_op    <= OP_READ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if ((state == SERVE_I) && mem_ready) begin
        if_rdata <= mem_rdata;
      end
      if ((state == SERVE_D) && mem_ready && (lat_op == OP_READ)) begin
        d_rdata <= mem_rdata;
      end
    end
  end

  // A redirected fetch still has to drain from memory; squash only hides its
  // completion from the front end.
  always_ff @(posedge clk) begin
    if (reset) begin
      squash <= 1'b0;
    end else if (next_state == IDLE) begin
      squash <= 1'b0;
    end else if (((state == SERVE_I) || (state == RESP_I)) && if_cancel) begin
      squash <= 1'b1;
    end
  end

  assign mem_valid = is_serve(state);
  assign mem_write = (state == SERVE_D) && (lat_op == OP_WRITE);
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  assign if_done   = (state == RESP_I) && !squash && !if_cancel;
  assign d_done    = (state == RESP_D);
  assign if_stall  = if_req && !if_done;
  assign d_stall   = d_req && !d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter with a delay-programmable memory model
// and a scoreboard of the memory transactions each scenario expects.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic            clk;
  logic            reset;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_cancel;
  logic            d_req;
  logic            d_write;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            if_done;
  logic            d_done;
  logic [XLEN-1:0] if_rdata;
  logic [XLEN-1:0] d_rdata;
  logic            if_stall;
  logic            d_stall;
  logic            mem_valid;
  logic            mem_write;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_cancel (if_cancel),
    .d_req     (d_req),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .if_done   (if_done),
    .d_done    (d_done),
    .if_rdata  (if_rdata),
    .d_rdata   (d_rdata),
    .if_stall  (if_stall),
    .d_stall   (d_stall),
    .mem_valid (mem_valid),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] addr;
    logic            write;
    logic [XLEN-1:0] wdata;
  } txn_t;

  txn_t            exp_q[$];
  int              n_checks;
  int              n_fail;
  int              ready_delay;
  int              wait_cnt;
  logic [XLEN-1:0] exp_d_rdata;

  function automatic logic [XLEN-1:0] mem_model(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_txn(input logic [XLEN-1:0] a, input logic w, input logic [XLEN-1:0] wd);
    txn_t t;
    t.addr  = a;
    t.write = w;
    t.wdata = wd;
    exp_q.push_back(t);
  endtask

  // Memory: raises mem_ready after ready_delay stalled cycles and checks each
  // accepted transaction against the scoreboard.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_valid === 1'b1 && reset === 1'b0) begin
        if (wait_cnt >= ready_delay) begin
          mem_ready = 1'b1;
          mem_rdata = mem_model(mem_addr);
          wait_cnt  = 0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL mem_txn_unexpected: got addr=%h write=%b, expected no transaction", mem_addr, mem_write);
          end else begin
            txn_t t;
            t = exp_q.pop_front();
            if (mem_addr !== t.addr || mem_write !== t.write || (t.write && mem_wdata !== t.wdata)) begin
              n_fail++;
              $display("FAIL mem_txn: got addr=%h write=%b wdata=%h, expected addr=%h write=%b wdata=%h",
                       mem_addr, mem_write, mem_wdata, t.addr, t.write, t.wdata);
            end
          end
        end else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  task automatic wait_done(input bit fetch, input int max_cycles, output int lat, output int vcnt, output bit ok);
    lat  = 0;
    vcnt = 0;
    ok   = 1'b0;
    for (int i = 1; i <= max_cycles; i++) begin
      tick();
      if (mem_valid === 1'b1) vcnt++;
      if ((fetch ? if_done : d_done) === 1'b1) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b0; if_addr = '0; if_cancel = 1'b0;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    ready_delay = 0;
    exp_d_rdata = '0;
    tick();
    tick();
    n_checks++;
    if ({mem_valid, mem_write, if_done, d_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid/write/if_done/d_done=%b, expected 0000", {mem_valid, mem_write, if_done, d_done});
    end
    n_checks++;
    if (if_rdata !== '0 || d_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got if_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h, expected all 0", if_rdata, d_rdata, mem_addr, mem_wdata);
    end
    n_checks++;
    if (dut.state !== IDLE || dut.starve_cnt !== 3'd0 || dut.squash !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d starve=%0d squash=%b, expected 0 0 0", dut.state, dut.starve_cnt, dut.squash);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch_basic();
    int lat, vcnt;
    bit ok;
    ready_delay = 0;
    expect_txn(32'h100, 1'b0, '0);
    if_addr = 32'h100;
    if_req  = 1'b1;
    wait_done(1'b1, 10, lat, vcnt, ok);
    n_checks++;
    if (!ok || lat != 2 || vcnt != 1) begin
      n_fail++;
      $display("FAIL fetch_latency: got done=%b lat=%0d valid_cycles=%0d, expected 1 2 1", ok, lat, vcnt);
    end
    n_checks++;
    if (if_rdata !== mem_model(32'h100) || if_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_rdata: got rdata=%h stall=%b, expected %h 0", if_rdata, if_stall, mem_model(32'h100));
    end
    if_req = 1'b0;
    tick();
    n_checks++;
    if (if_done !== 1'b0 || dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL fetch_pulse: got if_done=%b state=%0d, expected 0 0", if_done, dut.state);
    end
  endtask

  task automatic test_data_read();
    int lat, vcnt;
    bit ok;
    ready_delay = 1;
    expect_txn(32'h240, 1'b0, '0);
    d_addr  = 32'h240;
    d_write = 1'b0;
    d_req   = 1'b1;
    wait_done(1'b0, 10, lat, vcnt, ok);
    exp_d_rdata = mem_model(32'h240);
    n_checks++;
    if (!ok || lat != 3 || d_rdata !== exp_d_rdata || d_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL data_read: got done=%b lat=%0d rdata=%h stall=%b, expected 1 3 %h 0", ok, lat, d_rdata, d_stall, exp_d_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    ready_delay = 0;
    expect_txn(32'h200, 1'b1, 32'hDEADBEEF);
    expect_txn(32'h300, 1'b0, '0);
    if_addr = 32'h300; if_req = 1'b1;
    d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_write = 1'b1; d_req = 1'b1;
    tick();
    n_checks++;
    if ({mem_valid, mem_write} !== 2'b11 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL prio_data_first: got valid/write=%b addr=%h wdata=%h, expected 11 200 deadbeef", {mem_valid, mem_write}, mem_addr, mem_wdata);
    end
    tick();
    n_checks++;
    if (d_done !== 1'b1 || if_done !== 1'b0 || d_rdata !== exp_d_rdata || if_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_d_done: got d_done=%b if_done=%b d_rdata=%h if_stall=%b, expected 1 0 %h 1", d_done, if_done, d_rdata, if_stall, exp_d_rdata);
    end
    d_req = 1'b0; d_write = 1'b0;
    tick();
    n_checks++;
    if (mem_valid !== 1'b0 || dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL prio_idle: got valid=%b state=%0d, expected 0 0", mem_valid, dut.state);
    end
    tick();
    n_checks++;
    if ({mem_valid, mem_write} !== 2'b10 || mem_addr !== 32'h300) begin
      n_fail++;
      $display("FAIL prio_fetch_grant: got valid/write=%b addr=%h, expected 10 300", {mem_valid, mem_write}, mem_addr);
    end
    tick();
    n_checks++;
    if (if_done !== 1'b1 || if_rdata !== mem_model(32'h300) || dut.starve_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL prio_fetch_done: got if_done=%b rdata=%h starve=%0d, expected 1 %h 0", if_done, if_rdata, dut.starve_cnt, mem_model(32'h300));
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int  model_cnt;
    bit  exp_fetch, got_fetch, ok;
    logic [XLEN-1:0] cur_d;
    ready_delay = 0;
    model_cnt   = 0;
    if_addr = 32'h400; if_req = 1'b1;
    d_addr = 32'h1000; d_write = 1'b0; d_req = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_fetch = (model_cnt == STARVE_MAX);
      cur_d     = d_addr;
      if (exp_fetch) expect_txn(if_addr, 1'b0, '0);
      else           expect_txn(cur_d, 1'b0, '0);
      ok = 1'b0;
      got_fetch = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (if_done === 1'b1 || d_done === 1'b1) begin
          ok = 1'b1;
          got_fetch = (if_done === 1'b1);
          break;
        end
      end
      if (exp_fetch) model_cnt = 0;
      else if (model_cnt < STARVE_MAX) model_cnt++;
      n_checks++;
      if (!ok || got_fetch !== exp_fetch) begin
        n_fail++;
        $display("FAIL starve_grant%0d: got done=%b fetch=%b, expected 1 %b", g, ok, got_fetch, exp_fetch);
      end
      n_checks++;
      if (dut.starve_cnt !== 3'(model_cnt)) begin
        n_fail++;
        $display("FAIL starve_cnt%0d: got %0d, expected %0d", g, dut.starve_cnt, model_cnt);
      end
      if (!exp_fetch) begin
        exp_d_rdata = mem_model(cur_d);
        n_checks++;
        if (d_rdata !== exp_d_rdata) begin
          n_fail++;
          $display("FAIL starve_rdata%0d: got %h, expected %h", g, d_rdata, exp_d_rdata);
        end
        d_addr = d_addr + 32'h4;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
  endtask

  task automatic test_cancel();
    int  lat, dones;
    bit  stall_bad;
    ready_delay = 3;
    expect_txn(32'h500, 1'b0, '0);
    if_addr = 32'h500;
    if_req  = 1'b1;
    tick();
    n_checks++;
    if (mem_valid !== 1'b1 || dut.state !== SERVE_I) begin
      n_fail++;
      $display("FAIL cancel_serve: got valid=%b state=%0d, expected 1 %0d", mem_valid, dut.state, SERVE_I);
    end
    if_cancel = 1'b1;
    if_addr   = 32'h600;
    expect_txn(32'h600, 1'b0, '0);
    tick();
    if_cancel = 1'b0;
    lat = 0; dones = 0; stall_bad = 1'b0;
    for (int i = 3; i <= 30; i++) begin
      tick();
      if (if_done === 1'b1) begin
        dones++;
        lat = i;
        break;
      end
      if (if_stall !== 1'b1) stall_bad = 1'b1;
    end
    n_checks++;
    if (dones != 1 || lat != 11) begin
      n_fail++;
      $display("FAIL cancel_done: got dones=%0d at cycle %0d, expected 1 at cycle 11", dones, lat);
    end
    n_checks++;
    if (stall_bad || if_rdata !== mem_model(32'h600)) begin
      n_fail++;
      $display("FAIL cancel_stall_rdata: got stall_dropped=%b rdata=%h, expected 0 %h", stall_bad, if_rdata, mem_model(32'h600));
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_cancel_same_cycle();
    ready_delay = 0;
    expect_txn(32'h680, 1'b0, '0);
    if_addr = 32'h680;
    if_req  = 1'b1;
    tick();
    if_cancel = 1'b1;
    tick();
    if_cancel = 1'b0;
    n_checks++;
    if (dut.state !== RESP_I || if_done !== 1'b0 || if_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL cancel_same_cycle: got state=%0d if_done=%b stall=%b, expected %0d 0 1", dut.state, if_done, if_stall, RESP_I);
    end
    if_req = 1'b0;
    tick();
    n_checks++;
    if (dut.state !== IDLE || dut.squash !== 1'b0) begin
      n_fail++;
      $display("FAIL squash_clear: got state=%0d squash=%b, expected 0 0", dut.state, dut.squash);
    end
  endtask

  task automatic test_reset_in_serve();
    ready_delay = 1000;
    d_addr = 32'h800; d_wdata = 32'hCAFE_F00D; d_write = 1'b1; d_req = 1'b1;
    tick();
    n_checks++;
    if (dut.state !== SERVE_D || mem_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_serve_setup: got state=%0d valid=%b, expected %0d 1", dut.state, mem_valid, SERVE_D);
    end
    reset = 1'b1;
    d_req = 1'b0; d_write = 1'b0;
    tick();
    exp_d_rdata = '0;
    n_checks++;
    if (dut.state !== IDLE || {mem_valid, mem_write, d_done, if_done} !== 4'b0000 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL rst_serve: got state=%0d valid/write/d_done/if_done=%b addr=%h, expected 0 0000 0",
               dut.state, {mem_valid, mem_write, d_done, if_done}, mem_addr);
    end
    tick();
    reset = 1'b0;
    n_checks++;
    if (d_done !== 1'b0 || d_rdata !== '0) begin
      n_fail++;
      $display("FAIL rst_serve_nodone: got d_done=%b d_rdata=%h, expected 0 0", d_done, d_rdata);
    end
    ready_delay = 0;
    tick();
  endtask

  task automatic test_hold();
    int lat, vcnt;
    bit ok;
    ready_delay = 10;
    expect_txn(32'h900, 1'b1, 32'h1234_5678);
    d_addr = 32'h900; d_wdata = 32'h1234_5678; d_write = 1'b1; d_req = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_write = 1'($urandom_range(0, 1));
      if_addr = $urandom;
      tick();
      n_checks++;
      if ({mem_valid, mem_write} !== 2'b11 || mem_addr !== 32'h900 || mem_wdata !== 32'h1234_5678) begin
        n_fail++;
        $display("FAIL hold_stable%0d: got valid/write=%b addr=%h wdata=%h, expected 11 900 12345678",
                 i, {mem_valid, mem_write}, mem_addr, mem_wdata);
      end
    end
    wait_done(1'b0, 5, lat, vcnt, ok);
    n_checks++;
    if (!ok || lat != 1 || d_rdata !== exp_d_rdata) begin
      n_fail++;
      $display("FAIL hold_done: got done=%b lat=%0d d_rdata=%h, expected 1 1 %h", ok, lat, d_rdata, exp_d_rdata);
    end
    d_req = 1'b0; d_write = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fetch_basic();
    test_data_read();
    test_priority();
    test_starvation();
    test_cancel();
    test_cancel_same_cycle();
    test_reset_in_serve();
    test_hold();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d transactions never issued, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
